// File: rtl/req_arb4_pkg.sv
// Shared constants and FSM state encoding for the req_arb4 grant sequencer.
package req_arb4_pkg;
    localparam int REQ_N = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;
endpackage

// File: rtl/req_arb4_pri_enc.sv
// 4-input fixed-priority encoder: index 3 wins, nonzero_o flags any set input.
module pri_enc4
    import req_arb4_pkg::*;
(
    input  logic [REQ_N-1:0] din_i,
    output logic [IDX_W-1:0] index_o,
    output logic             nonzero_o
);
    always_comb begin
        index_o   = 2'd0;
        nonzero_o = |din_i;
        if (din_i[3])      index_o = 2'd3;
        else if (din_i[2]) index_o = 2'd2;
        else if (din_i[1]) index_o = 2'd1;
        else               index_o = 2'd0;
    end
endmodule

// File: rtl/req_arb4.sv
// Sticky request collector with valid/ready grant and busy hold until done.
// Optional forced release after TIMEOUT busy cycles: define REQ_ARB4_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for any pending request
// ST_OFFER | grant offered on gnt_valid/gnt_index, waiting for gnt_ready
// ST_BUSY  | granted requester in service, waiting for done (or timeout)
module req_arb4
    import req_arb4_pkg::*;
#(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] req,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_index,
    input  logic             gnt_ready,
    input  logic             done,
    output logic             busy,
    output logic [REQ_N-1:0] pending,
    output logic             timeout
);
    if (TIMEOUT >= (2 ** TO_W) || TIMEOUT < 1) begin : g_bad_cfg
        $error("req_arb4: TIMEOUT must be in 1 .. 2**TO_W-1");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REQ_N-1:0] pend_q, pend_d;
    logic [REQ_N-1:0] clr_mask;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_nz;

    pri_enc4 u_enc (
        .din_i     (pend_q),
        .index_o   (enc_idx),
        .nonzero_o (enc_nz)
    );

`ifdef REQ_ARB4_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            to_q, to_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_mask = '0;
`ifdef REQ_ARB4_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enc_nz) begin
                    idx_d   = enc_idx;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (gnt_ready) begin
                    clr_mask = 4'b0001 << idx_q;
                    state_d  = ST_BUSY;
`ifdef REQ_ARB4_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
`ifdef REQ_ARB4_TIMEOUT_EN
                // Last allowed busy cycle: done on this same edge is a normal completion.
                else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        // A new request on the accepting edge survives the clear.
        pend_d = (pend_q & ~clr_mask) | req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

`ifdef REQ_ARB4_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt_valid = (state_q == ST_OFFER);
    assign busy      = (state_q == ST_BUSY);
    assign gnt_index = idx_q;
    assign pending   = pend_q;
endmodule

// File: tb/tb_req_arb4.sv
// Randomized and directed bench for req_arb4 with a transaction-level reference model
// and a grant-index scoreboard checked at each accepted handshake.
module tb_req_arb4;
    localparam int TO = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       gnt_valid;
    logic [1:0] gnt_index;
    logic       gnt_ready;
    logic       done;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;

    req_arb4 #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_index (gnt_index),
        .gnt_ready (gnt_ready),
        .done      (done),
        .busy      (busy),
        .pending   (pending),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    // Reference model: phase 0 = waiting, 1 = offering, 2 = in service.
    int       m_phase;
    int       m_idx;
    bit [3:0] m_pend;
    int       m_busy_cycles;
    bit       m_to;
    bit [3:0] p_req;
    bit       p_rdy;
    bit       p_dn;

    function automatic int highest(bit [3:0] p);
        for (int i = 3; i >= 0; i--) if (p[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_pend = 0; m_busy_cycles = 0; m_to = 0;
        p_req = 0; p_rdy = 0; p_dn = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit [3:0] served;
        served = 4'b0000;
        m_to = 0;
        case (m_phase)
            0: if (m_pend != 0) begin
                m_idx = highest(m_pend);
                m_phase = 1;
                exp_q.push_back(m_idx);
            end
            1: if (p_rdy) begin
                served[m_idx] = 1'b1;
                m_phase = 2;
                m_busy_cycles = 0;
            end
            2: if (p_dn) m_phase = 0;
               else begin
                   m_busy_cycles++;
`ifdef REQ_ARB4_TIMEOUT_EN
                   if (m_busy_cycles == TO) begin
                       m_phase = 0;
                       m_to = 1;
                   end
`endif
               end
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~served) | p_req;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic check_model();
        logic [6:0] want;
        want = {m_phase == 1, m_phase == 2, m_to, m_pend};
        chk("outputs", {25'd0, gnt_valid, busy, timeout, pending}, {25'd0, want});
        if (m_phase == 1) chk("offer_index", {30'd0, gnt_index}, m_idx);
    endtask

    task automatic cyc(input logic [3:0] r, input logic rdy, input logic dn);
        req = r; gnt_ready = rdy; done = dn;
        p_req = r; p_rdy = rdy; p_dn = dn;
        @(posedge clk);
        #1;
        model_step();
        check_model();
    endtask

    // Scoreboard monitor: an accepted handshake pops the next expected grant.
    always @(negedge clk) begin
        if (!rst && gnt_valid && gnt_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL grant_sb: accepted index %0d with no expected grant", gnt_index);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(gnt_index) != e) begin
                    miscompares++;
                    $display("FAIL grant_sb: accepted index %0d expected %0d", gnt_index, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 0; gnt_ready = 0; done = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", {gnt_valid, busy, timeout, gnt_index, pending}, 9'd0);

        // Single pulse on index 1 with ready held high.
        cyc(4'b0010, 1, 0);
        chk("pulse_pending", {gnt_valid, pending}, 5'b0_0010);
        cyc(4'b0000, 1, 0);
        chk("pulse_offer", {gnt_valid, gnt_index}, 3'b1_01);
        cyc(4'b0000, 1, 0);
        chk("pulse_busy", {busy, gnt_valid, pending}, 6'b10_0000);
        cyc(4'b0000, 0, 1);

        // Two requests: index 2 then index 0 with an idle gap.
        cyc(4'b0101, 0, 0);
        cyc(4'b0000, 0, 0);
        chk("pair_first", {gnt_valid, gnt_index}, 3'b1_10);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 0, 1);
        chk("pair_idle_gap", {gnt_valid, busy}, 2'b00);
        cyc(4'b0000, 0, 0);
        chk("pair_second", {gnt_valid, gnt_index}, 3'b1_00);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 0, 1);

        // Higher request during an offer does not change the offered index.
        cyc(4'b0010, 0, 0);
        cyc(4'b0000, 0, 0);
        cyc(4'b1000, 0, 0);
        chk("offer_hold", {gnt_valid, gnt_index}, 3'b1_01);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000, 0, 0);
        chk("offer_next", {gnt_valid, gnt_index}, 3'b1_11);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 0, 1);

        // Re-request on the accepting edge keeps the pending bit.
        cyc(4'b0100, 0, 0);
        cyc(4'b0000, 0, 0);
        cyc(4'b0100, 1, 0);
        chk("set_wins", {busy, pending}, 5'b1_0100);
        cyc(4'b0000, 0, 1);
        cyc(4'b0000, 0, 0);
        chk("regrant", {gnt_valid, gnt_index}, 3'b1_10);
        cyc(4'b0000, 1, 0);
        cyc(4'b0000, 0, 1);

        // Busy without done.
        cyc(4'b0001, 0, 0);
        cyc(4'b0000, 0, 0);
        cyc(4'b0000, 1, 0);
        repeat (4) cyc(4'b0000, 0, 0);
        chk("busy_held", {busy, timeout}, 2'b10);
        cyc(4'b0000, 0, 0);
`ifdef REQ_ARB4_TIMEOUT_EN
        chk("timeout_fire", {busy, timeout}, 2'b01);
        cyc(4'b0000, 0, 0);
        chk("timeout_pulse_end", {busy, timeout}, 2'b00);
`else
        chk("no_timeout", {busy, timeout}, 2'b10);
        cyc(4'b0000, 0, 1);
`endif

        // Reset in the middle of a busy grant on index 2.
        cyc(4'b0100, 0, 0);
        cyc(4'b0000, 0, 0);
        cyc(4'b0000, 1, 0);
        cyc(4'b1011, 0, 0);
        rst = 1'b1; req = 0; gnt_ready = 0; done = 0;
        #2;
        chk("reset_mid_busy", {gnt_valid, busy, timeout, gnt_index, pending}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(4'b0000, 1, 0);
        chk("no_spurious", {gnt_valid, busy, pending}, 6'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 7) == 0);
            cyc(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/req_arb4.md
# req_arb4

Sticky request collector and grant sequencer for four requesters. It latches pulsed requests, selects the highest pending index with the team's 4-input fixed-priority encoder, offers that index on a valid/ready grant port, and holds the grant busy until the served requester signals completion. It sits between the raw request lines and a shared resource controller, and turns the encoder's combinational result into a registered, handshaked grant stream.

## Interface
- `TIMEOUT`, default 200: maximum BUSY cycles before forced release (used only with the configuration macro).
- `TO_W`, default 8: width of the timeout counter; must satisfy `TIMEOUT < 2**TO_W`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: request pulses, one bit per requester; any-length assertion.
- `gnt_valid` out 1: a grant offer is pending.
- `gnt_index` out 2: granted requester index; stable while `gnt_valid`=1.
- `gnt_ready` in 1: consumer accepts the offer.
- `done` in 1: served requester finished; ends BUSY.
- `busy` out 1: a granted transaction is in service.
- `pending` out 4: sticky request register.
- `timeout` out 1: one-cycle pulse on forced release (tied 0 without the macro).

## Operation
- States: IDLE, OFFER, BUSY (2-bit encoding).
- `pending` update each edge: `pending <= (pending & ~clr_mask) | req`. Set wins over clear on the same bit in the same cycle.
- IDLE: if `pending != 0`, latch `gnt_index` = highest set bit of `pending` and go to OFFER. Otherwise stay in IDLE.
- OFFER: `gnt_valid`=1. On `gnt_ready`=1, clear `pending[gnt_index]` and go to BUSY. `gnt_index` is not re-evaluated while in OFFER, even if a higher request arrives.
- BUSY: `busy`=1. On `done`=1, go to IDLE. `done` in IDLE or OFFER is ignored.
- Priority: index 3 highest, index 0 lowest. There is no fairness; a continuously re-requesting index 3 can starve lower indices.
- Reset, asserted at any time, including mid-OFFER or mid-BUSY: state returns to IDLE. Reset values: `pending`=0, `gnt_valid`=0, `gnt_index`=2'b00, `busy`=0, `timeout`=0, counter=0.

## Timing
- Request pulse before edge E0 → `pending` bit set after E0 → `gnt_valid` high after E1. Request-to-offer latency is 2 cycles.
- The handshake completes on the edge where `gnt_valid & gnt_ready`. `busy` rises, and `gnt_valid` falls, after that same edge.
- `done` at edge Ek → IDLE after Ek. The next `gnt_valid` can rise after Ek+1, giving a minimum 1 IDLE cycle between grants.
- `gnt_ready` held high before the offer has no effect until OFFER. Acceptance takes a minimum of 1 cycle in OFFER.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `REQ_ARB4_TIMEOUT_EN` defined: a counter clears on BUSY entry and increments each BUSY cycle.
  - When the counter reaches `TIMEOUT` without `done`, state goes to IDLE and `timeout` pulses for exactly 1 cycle.
  - `done` on the same edge as expiry counts as a normal completion, with no pulse.
- Not defined: no counter. BUSY waits indefinitely for `done`, and `timeout` is constant 0.

## Structure
- Shared package: state encodings `ST_IDLE`/`ST_OFFER`/`ST_BUSY` and `REQ_N`=4 / `IDX_W`=2 constants.
- One sub-module: instantiate the existing `pri_enc4` on `pending` to produce the select index and the nonzero flag. Its `index` is captured into `gnt_index` on IDLE→OFFER.

## Test plan
- Reset mid-BUSY (`gnt_index`=2) → after reset, all outputs are 0 and `pending`=0, and no spurious `gnt_valid`.
- Single pulse `req`=4'b0010 at cycle 0, `gnt_ready`=1 → `gnt_valid`=1 and `gnt_index`=1 at cycle 2, `busy`=1 at cycle 3, `pending`=0.
- `req`=4'b0101 pulse, then `done` after each grant → grants in order index 2, then index 0, with 1 IDLE cycle between.
- During OFFER(index 1), pulse `req[3]` → `gnt_index` stays 1 until accepted; next grant is index 3.
- `req[2]` pulsed on the same edge that accepts index 2 → `pending[2]` remains 1 and is re-granted after `done`.
- With `REQ_ARB4_TIMEOUT_EN` and `TIMEOUT`=5, no `done` → `busy` drops and `timeout` pulses 1 cycle, 5 cycles after BUSY entry. Without the macro, `busy` stays high.
